// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 forward cipher. One round per clock, with a
// valid/ready input and output stage. Round keys come pre-expanded on key_out
// and are not latched.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds in/in_valid until in_ready; the DUT holds out/out_valid
// until out_ready. in_ready is combinational and may depend on out_ready.
module aes_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            in,
  input  logic [128*(Nr+1)-1:0]   key_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out,
  output logic                    busy
);

  localparam int RW = $clog2(Nr + 1);
  localparam logic [RW-1:0] LAST = RW'(Nr);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   round;
  logic [127:0]    st;
  logic            accept;
  logic [127:0]    rk_cur, sr_st, full_round, last_round;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r,c) lives at bits [127-32c-8r -: 8]; column-major like the input.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        r[127-32*c-8*rr -: 8] = sbox(s[127-32*((c+rr)%4)-8*rr -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Round datapath: SubBytes+ShiftRows shared by normal and final rounds.
  always_comb begin
    rk_cur     = key_out[128*int'(round) +: 128];
    sr_st      = sub_shift(st);
    full_round = mix_columns(sr_st) ^ rk_cur;
    last_round = sr_st ^ rk_cur;
  end

  // Handshake decode and next-state selection.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (round == LAST) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = ROUND;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ROUND);

  // State register, round counter, cipher state and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round     <= '0;
      st        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == DONE) && out_ready) out_valid <= 1'b0;
      if (accept) begin
        st    <= in ^ key_out[127:0];
        round <= RW'(1);
      end else if (state == ROUND) begin
        if (round == LAST) begin
          out       <= last_round;
          out_valid <= 1'b1;
          round     <= '0;
        end else begin
          st    <= full_round;
          round <= round + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: Nr=10 and Nr=14 instances against a byte-matrix
// AES model whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes_cipher_iter;

  logic clk, rst;

  logic            in_valid10, in_ready10, out_valid10, out_ready10, busy10;
  logic [127:0]    din10, dout10;
  logic [1407:0]   key10;

  logic            in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0]    din14, dout14;
  logic [1919:0]   key14;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_q[$];
  logic [7:0]   sb_t [256];

  aes_cipher_iter #(.Nk(4), .Nr(10)) u10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10), .in(din10),
    .key_out(key10), .out_valid(out_valid10), .out_ready(out_ready10), .out(dout10),
    .busy(busy10)
  );

  aes_cipher_iter #(.Nk(8), .Nr(14)) u14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14), .in(din14),
    .key_out(key14), .out_valid(out_valid14), .out_ready(out_ready14), .out(dout14),
    .busy(busy14)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; round key r goes to ks[128*r +: 128].
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1919:0] ks,
                                           input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] rk, res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(r+4*c) -: 8];
    for (int rnd = 0; rnd <= nr; rnd++) begin
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r][c] = sb_t[s[r][(c+r)%4]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            if (rnd < nr)
              s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^
                        t[(r+2)%4][c] ^ t[(r+3)%4][c];
            else
              s[r][c] = t[r][c];
      end
      rk = ks[128*rnd +: 128];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rk[127-8*(r+4*c) -: 8];
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One block through the Nr=10 instance; hold = cycles of out_ready=0 after
  // out_valid, during which a competing in_valid is presented.
  task automatic run10(input logic [127:0] pt, input logic [1919:0] ks, input int hold,
                       output logic [127:0] res, output int lat);
    chk("in_ready_idle", in_ready10, 1);
    exp_q.push_back(aes_ref(pt, ks, 10));
    key10 = ks[1407:0];
    din10 = pt;
    in_valid10 = 1'b1;
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    lat = 1;
    chk("busy_after_accept", busy10, 1);
    while (out_valid10 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_rise", out_valid10, 1);
    res = dout10;
    for (int h = 0; h < hold; h++) begin
      in_valid10 = 1'b1;
      din10 = ~pt;
      @(posedge clk); #1;
      chk("hold_out_stable", dout10, res);
      chk("hold_out_valid", out_valid10, 1);
      chk("hold_in_ready", in_ready10, 0);
    end
    in_valid10 = 1'b0;
    out_ready10 = 1'b1;
    @(posedge clk); #1;
    out_ready10 = 1'b0;
    chk("out_valid_drop", out_valid10, 0);
    chk("idle_after_handshake", {busy10, in_ready10}, 2'b01);
    chk("scoreboard10", res, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1919:0] ka, kb, kr;
    logic [255:0]  k256;
    logic [127:0]  pa, pb, pr, res, e14;
    int            lat, t1, t2, cyc, ov_cnt;

    rst = 1'b1;
    in_valid10 = 0; out_ready10 = 0; din10 = '0; key10 = '0;
    in_valid14 = 0; out_ready14 = 0; din14 = '0; key14 = '0;
    build_sbox();

    ka = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    kb = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    pa = 128'h00112233445566778899aabbccddeeff;
    pb = 128'h3243f6a8885a308d313198a2e0370734;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid10, 0);
    chk("rst_out", dout10, 0);
    chk("rst_busy", busy10, 0);
    chk("rst_in_ready", in_ready10, 1);
    chk("rst_out_valid14", out_valid14, 0);
    @(posedge clk); #1;

    // Known-answer vectors, latency counted including the accept edge
    run10(pa, ka, 0, res, lat);
    chk("v1_latency", lat, 11);
    chk("v1_kat", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run10(pb, kb, 0, res, lat);
    chk("v2_kat", res, 128'h3925841d02dc09fbdc118597196a0b32);

    // Backpressure: 20 cycles of out_ready=0 with a competing in_valid
    run10(pa, ka, 20, res, lat);
    chk("bp_kat", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Back-to-back with out_ready tied high; second block held during ROUND
    out_ready10 = 1'b1;
    exp_q.push_back(aes_ref(pa, ka, 10));
    exp_q.push_back(aes_ref(pb, kb, 10));
    key10 = ka[1407:0]; din10 = pa; in_valid10 = 1'b1;
    @(posedge clk); #1;
    din10 = pb;
    cyc = 1;
    while (out_valid10 !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    t1 = cyc;
    chk("b2b_first_valid", out_valid10, 1);
    chk("b2b_first_kat", dout10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("b2b_first_sb", dout10, exp_q.pop_front());
    key10 = kb[1407:0];
    chk("b2b_in_ready_done", in_ready10, 1);
    @(posedge clk); #1;
    cyc++;
    in_valid10 = 1'b0;
    chk("b2b_busy_again", busy10, 1);
    while (out_valid10 !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    t2 = cyc;
    chk("b2b_gap", t2 - t1, 11);
    chk("b2b_second_kat", dout10, 128'h3925841d02dc09fbdc118597196a0b32);
    chk("b2b_second_sb", dout10, exp_q.pop_front());
    @(posedge clk); #1;
    out_ready10 = 1'b0;
    chk("b2b_idle", {out_valid10, in_ready10}, 2'b01);

    // Reset pulsed at round 5 aborts the block
    key10 = ka[1407:0]; din10 = pa; in_valid10 = 1'b1;
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("abort_out_valid", out_valid10, 0);
    chk("abort_out", dout10, 0);
    chk("abort_in_ready", in_ready10, 1);
    chk("abort_busy", busy10, 0);
    @(posedge clk); #1 rst = 1'b0;
    ov_cnt = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid10 !== 1'b0) ov_cnt++; end
    chk("abort_no_valid", ov_cnt, 0);
    run10(pb, kb, 1, res, lat);
    chk("after_abort_kat", res, 128'h3925841d02dc09fbdc118597196a0b32);

    // Randomized blocks on Nr=10
    for (int i = 0; i < 6; i++) begin
      kr = expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4, 10);
      pr = {$urandom, $urandom, $urandom, $urandom};
      run10(pr, kr, $urandom_range(0, 3), res, lat);
      chk("rand_latency", lat, 11);
    end

    // Nr=14 instance: FIPS-197 AES-256 vector, then random keys
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pr   = pa;
      end else begin
        k256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pr   = {$urandom, $urandom, $urandom, $urandom};
      end
      kr  = expand(k256, 8, 14);
      e14 = aes_ref(pr, kr, 14);
      chk("in_ready14_idle", in_ready14, 1);
      key14 = kr; din14 = pr; in_valid14 = 1'b1;
      @(posedge clk); #1;
      in_valid14 = 1'b0;
      lat = 1;
      while (out_valid14 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("nr14_latency", lat, 15);
      chk("nr14_model", dout14, e14);
      if (i == 0) chk("nr14_kat", dout14, 128'h8ea2b7ca516745bfeafc49904b496089);
      out_ready14 = 1'b1;
      @(posedge clk); #1;
      out_ready14 = 1'b0;
      chk("nr14_drop", out_valid14, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
